wide_stable_capture: RTL and testbench

- Destination-domain consumer of a per-bit-synchronized multi-bit bus, i.e. the output of the wide double-delay synchronizer.
- Per-bit synchronization can present transiently mixed old/new bit combinations. This block accepts a new bus value only after it has been sampled identical for STABLE_CYCLES consecutive clock edges.
- On acceptance it presents the value as a clean registered word with a one-cycle update pulse. Short excursions that return to the accepted value are flagged and discarded.

---
 rtl/wide_stable_capture_pkg.sv | 17 +
 rtl/gray_to_binary.sv | 20 ++
 rtl/wide_stable_capture.sv | 136 +++++++++++++
 tb/tb_wide_stable_capture.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/wide_stable_capture_pkg.sv
// Shared definitions for wide_stable_capture.
//
// Contents:
//   state_t   - settle FSM state encoding (IDLE / SETTLING)
//   cnt_width - width of a saturating counter that must hold the value stable_cycles
package wide_stable_capture_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      SETTLING = 1'b1
   } state_t;

   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Purely combinational Gray-to-binary converter.
// Reusable for any synchronized Gray-coded word, e.g. FIFO pointers.
//
// Parameters:
//   WIDTH  - word width in bits (>= 1)
// Ports:
//   gray   in  [WIDTH-1:0]  Gray-coded word
//   binary out [WIDTH-1:0]  binary equivalent; bit i = XOR of gray[WIDTH-1:i]
module gray_to_binary #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] binary
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign binary[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/wide_stable_capture.sv
// Destination-domain consumer of a per-bit-synchronized bus. A new bus value
// is accepted only after STABLE_CYCLES consecutive identical samples, then
// presented as a clean registered word with a one-cycle update pulse. Settling
// attempts that end back on the accepted value raise a one-cycle glitch pulse.
//
// Optional build macro: WIDE_STABLE_CAPTURE_GRAY_DECODE_EN
//   defined   - in_delayed is Gray code; comparisons stay in raw Gray and
//               out is the binary conversion of the accepted word
//   undefined - out is the accepted word itself
//
// Parameters:
//   WIDTH          - bus width (>= 1)
//   STABLE_CYCLES  - identical samples needed to accept a value (>= 2)
// Ports:
//   clk         in   destination clock, rising edge
//   rst         in   asynchronous reset, active low
//   in_delayed  in   [WIDTH-1:0] synchronized bus
//   out         out  [WIDTH-1:0] last accepted value, registered
//   update      out  one-cycle pulse when out takes a new value
//   glitch      out  one-cycle pulse when a settle ends on the accepted value
//   busy        out  high while settling
//
// State table:
//   IDLE     | input matches accepted word; waiting for a change
//   SETTLING | counting consecutive identical samples of a candidate value
module wide_stable_capture
   import wide_stable_capture_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_delayed,
   output logic [WIDTH-1:0] out,
   output logic             update,
   output logic             glitch,
   output logic             busy
);

   localparam int            CW       = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             update_q, update_d;
   logic             glitch_q, glitch_d;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      update_d = 1'b0;
      glitch_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_delayed != acc_q) begin
               state_d = SETTLING;
               last_d  = in_delayed;
               cnt_d   = CNT_ONE;
            end
         end
         SETTLING: begin
            if (in_delayed != last_q) begin
               // Any change restarts the count, even a return to acc.
               last_d = in_delayed;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               if (in_delayed != acc_q) begin
                  acc_d    = in_delayed;
                  update_d = 1'b1;
               end else begin
                  glitch_d = 1'b1;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         update_q <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         update_q <= update_d;
         glitch_q <= glitch_d;
      end
   end

`ifdef WIDE_STABLE_CAPTURE_GRAY_DECODE_EN
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] out_q;

   // Convert the next accepted word so out stays aligned with acc.
   gray_to_binary #(
      .WIDTH (WIDTH)
   ) u_gray_to_binary (
      .gray   (acc_d),
      .binary (bin_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else begin
         out_q <= bin_d;
      end
   end

   assign out = out_q;
`else
   assign out = acc_q;
`endif

   assign update = update_q;
   assign glitch = glitch_q;
   assign busy   = (state_q == SETTLING);

endmodule

// File: tb/tb_wide_stable_capture.sv
module tb_wide_stable_capture;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] din;
      logic [WIDTH-1:0] exp_raw;
      logic             exp_update;
      logic             exp_glitch;
      logic             exp_busy;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_delayed;
   logic [WIDTH-1:0] out;
   logic             update;
   logic             glitch;
   logic             busy;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   wide_stable_capture #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_delayed (in_delayed),
      .out        (out),
      .update     (update),
      .glitch     (glitch),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Expected out for an accepted raw word; independent bitwise loop.
   function automatic logic [WIDTH-1:0] exp_out(input logic [WIDTH-1:0] raw);
      logic [WIDTH-1:0] b;
`ifdef WIDE_STABLE_CAPTURE_GRAY_DECODE_EN
      b[WIDTH-1] = raw[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ raw[i];
`else
      b = raw;
`endif
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] raw,
                            input logic u, input logic g, input logic b);
      check({tag, "_out"},    32'(out),    32'(exp_out(raw)));
      check({tag, "_update"}, 32'(update), 32'(u));
      check({tag, "_glitch"}, 32'(glitch), 32'(g));
      check({tag, "_busy"},   32'(busy),   32'(b));
   endtask

   task automatic apply(input logic [WIDTH-1:0] d);
      in_delayed = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] raw,
                      input logic u, input logic g, input logic b);
      vec_t v;
      v.din = d; v.exp_raw = raw; v.exp_update = u; v.exp_glitch = g; v.exp_busy = b;
      vecs.push_back(v);
   endtask

   initial begin
      // Vector table, starting from accepted word 0x00.
      // Skewed arrival: 0x0C for one cycle, then 0x3C held.
      add(8'h0C, 8'h00, 0, 0, 1);
      add(8'h3C, 8'h00, 0, 0, 1);
      add(8'h3C, 8'h00, 0, 0, 1);
      add(8'h3C, 8'h00, 0, 0, 1);
      add(8'h3C, 8'h3C, 1, 0, 0);
      add(8'h3C, 8'h3C, 0, 0, 0);
      // Glitch rejection: 0x3D for two cycles, back to 0x3C.
      add(8'h3D, 8'h3C, 0, 0, 1);
      add(8'h3D, 8'h3C, 0, 0, 1);
      add(8'h3C, 8'h3C, 0, 0, 1);
      add(8'h3C, 8'h3C, 0, 0, 1);
      add(8'h3C, 8'h3C, 0, 0, 1);
      add(8'h3C, 8'h3C, 0, 1, 0);
      add(8'h3C, 8'h3C, 0, 0, 0);
      // Clean step to 0x5A.
      add(8'h5A, 8'h3C, 0, 0, 1);
      add(8'h5A, 8'h3C, 0, 0, 1);
      add(8'h5A, 8'h3C, 0, 0, 1);
      add(8'h5A, 8'h5A, 1, 0, 0);
      // Continuous toggle: stays settling, out frozen.
      for (int i = 0; i < 20; i++) add((i % 2 == 0) ? 8'h11 : 8'h22, 8'h5A, 0, 0, 1);
      // Hold the last toggle value (0x22 already sampled once).
      add(8'h22, 8'h5A, 0, 0, 1);
      add(8'h22, 8'h5A, 0, 0, 1);
      add(8'h22, 8'h22, 1, 0, 0);
      // Change right after acceptance is evaluated from IDLE.
      add(8'h77, 8'h22, 0, 0, 1);
      add(8'h77, 8'h22, 0, 0, 1);
      add(8'h77, 8'h22, 0, 0, 1);
      add(8'h77, 8'h77, 1, 0, 0);

      // Reset held with 0xA5 on the bus.
      rst = 1'b0;
      in_delayed = 8'hA5;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("in_reset", 8'h00, 0, 0, 0);
      rst = 1'b1;
      apply(8'hA5); check_all("rel_s1", 8'h00, 0, 0, 1);
      apply(8'hA5); check_all("rel_s2", 8'h00, 0, 0, 1);
      apply(8'hA5); check_all("rel_s3", 8'h00, 0, 0, 1);
      apply(8'hA5); check_all("rel_s4", 8'hA5, 1, 0, 0);

      // Reset mid-settle aborts with no pulse.
      apply(8'h99); check_all("abort_s1", 8'hA5, 0, 0, 1);
      apply(8'h99); check_all("abort_s2", 8'hA5, 0, 0, 1);
      #2 rst = 1'b0;
      #1 check_all("abort_rst", 8'h00, 0, 0, 0);
      in_delayed = 8'h00;
      @(posedge clk);
      #1;
      check_all("abort_hold", 8'h00, 0, 0, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(8'h00);
         check_all($sformatf("abort_post%0d", i), 8'h00, 0, 0, 0);
      end

      // Table-driven sequence.
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].din);
         check_all($sformatf("vec%0d", i), vecs[i].exp_raw,
                   vecs[i].exp_update, vecs[i].exp_glitch, vecs[i].exp_busy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
